// File: rtl/im_boot_ctrl.sv
// Boot-load controller and instruction fetch gate.
// Holds the CPU in reset while a length-prefixed little-endian word stream is
// written into instruction memory, then releases the CPU and masks every fetch
// that falls outside the loaded image with a NOP.
module im_boot_ctrl #(
  parameter int unsigned ADDR_BITS = 5,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  input  logic                 reload,
  input  logic [15:0]          pc,
  input  logic [31:0]          im_rdata,
  output logic [ADDR_BITS-1:0] im_raddr,
  output logic                 im_we,
  output logic [ADDR_BITS-1:0] im_waddr,
  output logic [31:0]          im_wdata,
  output logic [31:0]          instr,
  output logic                 fetch_fault,
  output logic                 cpu_rst,
  output logic [ADDR_BITS:0]   loaded_words
);

  // Full memory depth, one bit wider than a word address.
  localparam logic [ADDR_BITS:0] DepthW = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] IdxOne = {{ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StHdr,
    StLoad,
    StFlush,
    StRun
  } state_e;

  state_e               state_q, state_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 im_we_q, im_we_d;
  logic [ADDR_BITS-1:0] im_waddr_q, im_waddr_d;
  logic [31:0]          im_wdata_q, im_wdata_d;
  logic [ADDR_BITS:0]   loaded_words_q, loaded_words_d;
  logic [ADDR_BITS:0]   word_idx_q, word_idx_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [23:0]          asm_q, asm_d;

  logic                 accept;
  logic [31:0]          hdr_wide;
  logic [ADDR_BITS:0]   hdr_n;
  logic [ADDR_BITS:0]   word_idx_inc;

  // Handshake and header clamp; reset blocks any byte from being taken.
  always_comb begin
    rx_ready     = !reset && ((state_q == StHdr) || (state_q == StLoad));
    accept       = rx_valid && rx_ready;
    hdr_wide     = 32'(rx_data);
    hdr_n        = (hdr_wide > 32'(DepthW)) ? DepthW : hdr_wide[ADDR_BITS:0];
    word_idx_inc = word_idx_q + IdxOne;
  end

  // Next-state and load datapath; write strobe defaults low so it pulses.
  always_comb begin
    state_d        = state_q;
    cpu_rst_d      = cpu_rst_q;
    im_we_d        = 1'b0;
    im_waddr_d     = im_waddr_q;
    im_wdata_d     = im_wdata_q;
    loaded_words_d = loaded_words_q;
    word_idx_d     = word_idx_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;

    unique case (state_q)
      StHdr: begin
        if (accept) begin
          loaded_words_d = hdr_n;
          word_idx_d     = '0;
          byte_cnt_d     = '0;
          if (hdr_n == '0) begin
            state_d   = StRun;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        if (accept) begin
          if (byte_cnt_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_waddr_d = word_idx_q[ADDR_BITS-1:0];
            im_wdata_d = {rx_data, asm_q};
            word_idx_d = word_idx_inc;
            byte_cnt_d = '0;
            if (word_idx_inc == loaded_words_q) begin
              state_d = StFlush;
            end
          end else begin
            unique case (byte_cnt_q)
              2'd0:    asm_d[7:0]   = rx_data;
              2'd1:    asm_d[15:8]  = rx_data;
              default: asm_d[23:16] = rx_data;
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      // One cycle that carries the final write before the CPU is released.
      StFlush: begin
        state_d   = StRun;
        cpu_rst_d = 1'b0;
      end

      StRun: begin
        if (reload) begin
          state_d        = StHdr;
          cpu_rst_d      = 1'b1;
          loaded_words_d = '0;
          word_idx_d     = '0;
          byte_cnt_d     = '0;
        end
      end

      default: begin
        state_d   = StHdr;
        cpu_rst_d = 1'b1;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StHdr;
      cpu_rst_q      <= 1'b1;
      im_we_q        <= 1'b0;
      im_waddr_q     <= '0;
      im_wdata_q     <= '0;
      loaded_words_q <= '0;
      word_idx_q     <= '0;
      byte_cnt_q     <= '0;
      asm_q          <= '0;
    end else begin
      state_q        <= state_d;
      cpu_rst_q      <= cpu_rst_d;
      im_we_q        <= im_we_d;
      im_waddr_q     <= im_waddr_d;
      im_wdata_q     <= im_wdata_d;
      loaded_words_q <= loaded_words_d;
      word_idx_q     <= word_idx_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
    end
  end

  // Zero-latency fetch gate.
  always_comb begin
    im_raddr    = pc[ADDR_BITS+1:2];
    fetch_fault = (state_q != StRun) ||
                  (pc[1:0] != 2'b00) ||
                  (pc[15:ADDR_BITS+2] != '0) ||
                  ({1'b0, pc[ADDR_BITS+1:2]} >= loaded_words_q);
    instr       = fetch_fault ? NOP_INSTR : im_rdata;
  end

  assign im_we        = im_we_q;
  assign im_waddr     = im_waddr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign loaded_words = loaded_words_q;

endmodule

// File: tb/tb_im_boot_ctrl.sv
// Self-checking bench for im_boot_ctrl: a write scoreboard fed by the byte
// driver, a table of fetch-gate vectors, and hand-written load sequences.
module tb_im_boot_ctrl;

  localparam int unsigned AB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          reload;
  logic [15:0]   pc;
  logic [31:0]   im_rdata;
  logic [AB-1:0] im_raddr;
  logic          im_we;
  logic [AB-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic [31:0]   instr;
  logic          fetch_fault;
  logic          cpu_rst;
  logic [AB:0]   loaded_words;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [AB-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [15:0]   pc;
    logic [31:0]   rdata;
    logic [AB-1:0] raddr;
    logic [31:0]   instr;
    logic          fault;
  } fetch_vec_t;
  fetch_vec_t vecs[8];

  im_boot_ctrl #(.ADDR_BITS(AB), .NOP_INSTR(32'h00000013)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .reload       (reload),
    .pc           (pc),
    .im_rdata     (im_rdata),
    .im_raddr     (im_raddr),
    .im_we        (im_we),
    .im_waddr     (im_waddr),
    .im_wdata     (im_wdata),
    .instr        (instr),
    .fetch_fault  (fetch_fault),
    .cpu_rst      (cpu_rst),
    .loaded_words (loaded_words)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (im_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 im_waddr, im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(im_waddr), 32'(e.addr));
        check("write_data", im_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    check("rx_ready_at_send", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [AB-1:0] addr, input logic [31:0] w);
    wr_t e;
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    e.addr = addr;
    e.data = w;
    exp_q.push_back(e);
    send_byte(w[31:24]);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;

    vecs[0] = '{16'h0004, 32'hDEADBEEF, 5'd1,  32'hDEADBEEF, 1'b0};
    vecs[1] = '{16'h0000, 32'h100105B7, 5'd0,  32'h100105B7, 1'b0};
    vecs[2] = '{16'h0008, 32'h12345678, 5'd2,  32'h00000013, 1'b1};
    vecs[3] = '{16'h0002, 32'hAAAA5555, 5'd0,  32'h00000013, 1'b1};
    vecs[4] = '{16'h0100, 32'h0F0F0F0F, 5'd0,  32'h00000013, 1'b1};
    vecs[5] = '{16'h007C, 32'h11111111, 5'd31, 32'h00000013, 1'b1};
    vecs[6] = '{16'h0005, 32'h22222222, 5'd1,  32'h00000013, 1'b1};
    vecs[7] = '{16'h8004, 32'h33333333, 5'd1,  32'h00000013, 1'b1};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    pc       = 16'h0000;
    im_rdata = 32'h0;

    // Reset held for two cycles.
    @(posedge clk);
    #1;
    check("rx_ready_in_reset", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rx_ready_in_reset2", 32'(rx_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_waddr", 32'(im_waddr), 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_instr", instr, 32'h00000013);
    check("rst_fault", 32'(fetch_fault), 32'd1);
    check("rst_loaded", 32'(loaded_words), 32'd0);

    // Two-word load with continuous valid.
    send_byte(8'h02);
    send_word(5'd0, 32'h100105B7);
    send_word(5'd1, 32'h0005A283);
    check("flush_cpu_rst", 32'(cpu_rst), 32'd1);
    check("flush_rx_ready", 32'(rx_ready), 32'd0);
    check("flush_im_we", 32'(im_we), 32'd1);
    idle(1);
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("run_loaded", 32'(loaded_words), 32'd2);
    check("run_rx_ready", 32'(rx_ready), 32'd0);

    // Fetch-gate table with loaded_words = 2.
    for (int i = 0; i < 8; i++) begin
      pc       = vecs[i].pc;
      im_rdata = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d_raddr", i), 32'(im_raddr), 32'(vecs[i].raddr));
      check($sformatf("vec%0d_instr", i), instr, vecs[i].instr);
      check($sformatf("vec%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].fault));
    end
    pc = 16'h0000;
    im_rdata = 32'hCAFEBABE;

    // Reload to HDR.
    pulse_reload();
    check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reload_loaded", 32'(loaded_words), 32'd0);
    check("reload_rx_ready", 32'(rx_ready), 32'd1);

    // Empty image: RUN after one edge, every fetch faults.
    send_byte(8'h00);
    check("empty_cpu_rst", 32'(cpu_rst), 32'd0);
    check("empty_loaded", 32'(loaded_words), 32'd0);
    check("empty_fault_pc0", 32'(fetch_fault), 32'd1);
    check("empty_instr_pc0", instr, 32'h00000013);

    // Header clamp to full depth and full-memory load.
    pulse_reload();
    send_byte(8'hFF);
    check("clamp_loaded", 32'(loaded_words), 32'd32);
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'hC3};
      send_word(5'(i), w);
    end
    check("full_rx_ready", 32'(rx_ready), 32'd0);
    check("full_last_waddr", 32'(im_waddr), 32'd31);
    idle(1);
    check("full_cpu_rst", 32'(cpu_rst), 32'd0);
    pc = 16'h007C;
    im_rdata = 32'h0BADF00D;
    #1;
    check("full_fetch_top", instr, 32'h0BADF00D);
    pc = 16'h0080;
    #1;
    check("full_fetch_past", 32'(fetch_fault), 32'd1);
    pc = 16'h0000;

    // Gapped bytes with reload held through HDR and LOAD (must be ignored).
    pulse_reload();
    reload = 1'b1;
    send_byte(8'h01);
    send_byte(8'h44);
    idle(1);
    check("gap_rx_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h33);
    idle(2);
    check("gap_loaded", 32'(loaded_words), 32'd1);
    send_byte(8'h22);
    idle(1);
    check("gap_cpu_rst", 32'(cpu_rst), 32'd1);
    exp_q.push_back('{5'd0, 32'h11223344});
    reload = 1'b0;
    send_byte(8'h11);
    idle(1);
    check("gap_run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("gap_run_loaded", 32'(loaded_words), 32'd1);

    // Reset after three bytes of word 0.
    pulse_reload();
    send_byte(8'h02);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    reset = 1'b1;
    #1;
    check("midrst_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_im_we", 32'(im_we), 32'd0);
    check("midrst_rx_ready_after", 32'(rx_ready), 32'd1);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_loaded", 32'(loaded_words), 32'd0);

    // Fresh one-word image after the aborted load.
    send_byte(8'h01);
    send_word(5'd0, 32'hCAFEF00D);
    idle(1);
    check("post_rst_cpu_rst", 32'(cpu_rst), 32'd0);
    im_rdata = 32'hCAFEF00D;
    #1;
    check("post_rst_fetch", instr, 32'hCAFEF00D);
    idle(2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/im_boot_ctrl.md
# im_boot_ctrl

Boot-load controller and fetch gate for the single-cycle RISC-V core's instruction memory. After reset it holds the CPU in reset and accepts a byte stream: a length header, then little-endian 32-bit words. It writes those words into the instruction memory through its write port, then releases the CPU. While the CPU runs, it converts the CPU's byte PC to a word address and substitutes a NOP for any fetch outside the loaded image.

## Interface
Parameters:
- ADDR_BITS, 5, instruction-memory word-address width; depth = 2^ADDR_BITS words.
- NOP_INSTR, 32'h00000013, instruction returned on faulted or blocked fetch (addi x0,x0,0).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  incoming load byte.
- rx_ready  out  1  byte accepted at the rising edge where rx_valid && rx_ready.
- reload  in  1  in RUN: restart the load sequence; ignored in other states.
- pc  in  16  CPU byte program counter.
- im_rdata  in  32  instruction-memory read data for im_raddr (combinational read).
- im_raddr  out  ADDR_BITS  = pc[ADDR_BITS+1:2].
- im_we  out  1  instruction-memory write enable, registered.
- im_waddr  out  ADDR_BITS  write word address, registered.
- im_wdata  out  32  write data, registered.
- instr  out  32  instruction delivered to the CPU.
- fetch_fault  out  1  current fetch is out of image, misaligned, or blocked.
- cpu_rst  out  1  holds the CPU in reset, registered.
- loaded_words  out  ADDR_BITS+1  word count of the current image.

## Operation
- **States:** HDR, LOAD, FLUSH, RUN.
- **Reset values:**
  - State = HDR; cpu_rst = 1; im_we = 0; im_waddr = 0; im_wdata = 0.
  - loaded_words = 0; byte counter = 0; word index = 0.
- **rx_ready:** 1 in HDR and LOAD; 0 in FLUSH and RUN. Forced to 0 while reset is high.
- **HDR:**
  - On byte accept, N = rx_data; values above 2^ADDR_BITS clamp to 2^ADDR_BITS.
  - N stored to loaded_words.
  - N = 0: go to RUN. N > 0: go to LOAD with word index 0 and byte counter 0.
- **LOAD:**
  - Byte k of a word (k = 0..3) goes to assembly bits [8k+7:8k], little-endian.
  - Cycles without rx_valid hold all state.
  - On the 4th byte accept: next cycle im_we = 1, im_waddr = word index, im_wdata = assembled word. Then the word index increments and the byte counter clears.
  - If this was word N-1, go to FLUSH. Otherwise stay in LOAD; the next byte may be accepted in the im_we cycle.
- **FLUSH:** lasts exactly one cycle (the cycle carrying the final im_we), then go to RUN.
- **RUN:**
  - cpu_rst = 0, registered: it drops on the edge that enters RUN.
  - im_we = 0.
  - reload = 1 moves to HDR at the next edge: cpu_rst = 1, loaded_words = 0, counters cleared.
- **Fetch path (combinational):**
  - fetch_fault = 1 if any of the following holds:
    - state != RUN;
    - pc[1:0] != 0;
    - pc[15:ADDR_BITS+2] != 0;
    - pc[ADDR_BITS+1:2] >= loaded_words.
  - instr = NOP_INSTR when fetch_fault = 1; otherwise instr = im_rdata.
- **Reset mid-load:** partial word discarded, no im_we issued, return to HDR. Memory contents are untouched.
- **Simultaneous events:** reset has priority over everything. reload has no effect outside RUN. A byte is never accepted in FLUSH or RUN.

## Timing
- Byte accept to im_we: 1 cycle (rising edge after the 4th handshake).
- Last byte to cpu_rst low: 2 edges (LOAD→FLUSH, FLUSH→RUN). This keeps the last write from colliding with the CPU's first fetch.
- Header 0 to cpu_rst low: 1 edge.
- Sustained throughput: 1 byte per cycle; im_we is high at most once per 4 cycles during LOAD.
- Fetch path has zero latency: instr and fetch_fault follow pc and im_rdata in the same cycle.

## Test plan
1. **Reset:** assert reset for 2 cycles, then release.
   - During reset: rx_ready = 0.
   - After release: rx_ready = 1, cpu_rst = 1, im_we = 0, instr = 0x00000013, fetch_fault = 1, loaded_words = 0.
2. **Two-word load:** header 0x02, then bytes b7 05 01 10 83 a2 05 00, rx_valid continuous.
   - im_we pulses with (0, 0x100105b7), then (1, 0x0005a283).
   - FLUSH for 1 cycle, then RUN: cpu_rst = 0 two edges after the last byte; loaded_words = 2.
3. **Fetch gating in RUN (loaded_words = 2):**
   - pc = 0x0004: im_raddr = 1, instr = im_rdata, fault = 0.
   - pc = 0x0008: fault = 1, instr = 0x13.
   - pc = 0x0002: fault = 1.
   - pc = 0x0100: fault = 1.
4. **Empty image and clamping:**
   - Header 0x00: RUN after 1 edge, every fetch faults.
   - Header 0xFF (ADDR_BITS = 5): loaded_words = 32; after 128 bytes, rx_ready = 0 and the last im_waddr = 31.
5. **Gaps and reset mid-load:**
   - rx_valid toggled 1/0 during a word: word assembled correctly, no early im_we.
   - Reset after 3 bytes of word 0: no im_we, state HDR, rx_ready = 1.
6. **Reload:**
   - reload = 1 in RUN: next edge cpu_rst = 1, loaded_words = 0, rx_ready = 1.
   - New header 0x01 plus 4 bytes: single write at address 0, then RUN.
   - reload held during LOAD: ignored.
